// File: rtl/psram_qspi_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : psram_qspi_ctrl_if
//  Purpose  : Single-word valid/ready memory request bus between the core
//             and the quad-SPI PSRAM controller.
//  Signals  : valid  - request valid, held until ready
//             addr   - 24-bit byte address (addr[1:0] ignored)
//             wdata  - 32-bit write data, little-endian bytes
//             wstrb  - byte strobes, 4'b0000 means read
//             rdata  - read data, valid while ready=1
//             ready  - one-cycle completion pulse
//  Modports : master (request side), slave (controller side)
//  Revision : 1.0 - initial release
// ============================================================================
interface psram_qspi_ctrl_if;
   logic        valid;
   logic [23:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface
`default_nettype wire

// File: rtl/psram_qspi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : psram_qspi_ctrl
//  Purpose  : Quad-I/O SPI PSRAM initiator. Turns single-word bus requests
//             into EBh quad reads (with dummy clocks) or 38h quad writes.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             bus (slave)        - valid/addr/wdata/wstrb/rdata/ready
//             psram_sck_o        - serial clock
//             psram_ce_n_o       - chip enable, active low
//             psram_dio_out_o    - DIO output nibble
//             psram_dio_oe_o     - 1 = controller drives DIO
//             psram_dio_in_i     - DIO input nibble from the pads
//  Options  : PSRAM_RESET_SEQ_EN - issue 66h/99h reset commands after reset
//  Revision : 1.0 - initial release
// ============================================================================
module psram_qspi_ctrl #(
   parameter int DUMMY_CYCLES = 6,
   parameter int CE_HIGH      = 2
) (
   input  wire                 clk,
   input  wire                 rst,
   psram_qspi_ctrl_if.slave    bus,
   output logic                psram_sck_o,
   output logic                psram_ce_n_o,
   output logic [3:0]          psram_dio_out_o,
   output logic                psram_dio_oe_o,
   input  wire  [3:0]          psram_dio_in_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_RDATA  = 3'd4;
   localparam logic [2:0] S_WDATA  = 3'd5;
   localparam logic [2:0] S_CEHOLD = 3'd6;

   localparam logic [7:0] C_DUMMY_END = 8'(14 + DUMMY_CYCLES);
   localparam logic [7:0] C_RD_LAST   = 8'(22 + DUMMY_CYCLES);
   localparam logic [7:0] C_HOLD_RST  = 8'(CE_HIGH);
   localparam logic [7:0] C_HOLD_TXN  = 8'(CE_HIGH - 1);
`ifdef PSRAM_RESET_SEQ_EN
   localparam logic [1:0] C_SEQ_INIT  = 2'd2;   // 66h then 99h still to send
`else
   localparam logic [1:0] C_SEQ_INIT  = 2'd0;
`endif

   logic [2:0]  state_q, state_d;
   logic        sck_q, sck_d;
   logic        ready_q, ready_d;
   logic [7:0]  k_q, k_d;              // current SCK clock index (1-based)
   logic [7:0]  last_k_q, last_k_d;    // index of the final SCK clock
   logic [7:0]  hold_q, hold_d;        // remaining ce_n-high cycles
   logic [1:0]  seq_q, seq_d;          // pending PSRAM reset commands
   logic        rstcmd_q, rstcmd_d;    // command-only transaction, no ready
   logic        rd_q, rd_d;
   logic [7:0]  cmd_sr_q, cmd_sr_d;
   logic [23:0] addr_sr_q, addr_sr_d;
   logic [31:0] wr_sr_q, wr_sr_d;
   logic [31:0] rd_sr_q, rd_sr_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  w_first;
   logic [1:0]  w_last;
   logic [7:0]  w_wr_last;
   logic [31:0] w_wdata_al;
   logic        w_is_rd;
   logic        w_unused;

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Lowest/highest set strobe; write burst spans bytes first..last.
   always_comb begin
      w_first = 2'd0;
      w_last  = 2'd0;
      for (int i = 3; i >= 0; i--) if (bus.wstrb[i]) w_first = 2'(i);
      for (int i = 0; i < 4; i++)  if (bus.wstrb[i]) w_last  = 2'(i);
   end

   assign w_is_rd    = (bus.wstrb == 4'b0000);
   assign w_wr_last  = 8'd16 + {5'd0, (w_last - w_first), 1'b0};
   assign w_wdata_al = bus.wdata >> {w_first, 3'b000};
   assign w_unused   = &{1'b0, bus.addr[1:0]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sck_q     <= 1'b0;
         ready_q   <= 1'b0;
         k_q       <= 8'd0;
         last_k_q  <= 8'd0;
         hold_q    <= C_HOLD_RST;
         seq_q     <= C_SEQ_INIT;
         rstcmd_q  <= 1'b0;
         rd_q      <= 1'b0;
         cmd_sr_q  <= 8'd0;
         addr_sr_q <= 24'd0;
         wr_sr_q   <= 32'd0;
         rd_sr_q   <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         sck_q     <= sck_d;
         ready_q   <= ready_d;
         k_q       <= k_d;
         last_k_q  <= last_k_d;
         hold_q    <= hold_d;
         seq_q     <= seq_d;
         rstcmd_q  <= rstcmd_d;
         rd_q      <= rd_d;
         cmd_sr_q  <= cmd_sr_d;
         addr_sr_q <= addr_sr_d;
         wr_sr_q   <= wr_sr_d;
         rd_sr_q   <= rd_sr_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next-state logic. Active states alternate SCK rise / fall each clk;
   // outgoing data only advances on the fall, read data is taken on the rise.
   always_comb begin
      state_d   = state_q;
      sck_d     = sck_q;
      ready_d   = 1'b0;
      k_d       = k_q;
      last_k_d  = last_k_q;
      hold_d    = hold_q;
      seq_d     = seq_q;
      rstcmd_d  = rstcmd_q;
      rd_d      = rd_q;
      cmd_sr_d  = cmd_sr_q;
      addr_sr_d = addr_sr_q;
      wr_sr_d   = wr_sr_q;
      rd_sr_d   = rd_sr_q;
      rdata_d   = rdata_q;
      case (state_q)
         S_IDLE: begin
            sck_d = 1'b0;
            if (hold_q != 8'd0) begin
               hold_d = hold_q - 8'd1;
            end else if (seq_q != 2'd0) begin
               state_d  = S_CMD;
               k_d      = 8'd1;
               last_k_d = 8'd8;
               rstcmd_d = 1'b1;
               rd_d     = 1'b0;
               cmd_sr_d = (seq_q == 2'd2) ? 8'h66 : 8'h99;
            end else if (bus.valid) begin
               state_d   = S_CMD;
               k_d       = 8'd1;
               rstcmd_d  = 1'b0;
               rd_d      = w_is_rd;
               cmd_sr_d  = w_is_rd ? 8'hEB : 8'h38;
               addr_sr_d = {bus.addr[23:2], (w_is_rd ? 2'b00 : w_first)};
               wr_sr_d   = bswap(w_wdata_al);
               last_k_d  = w_is_rd ? C_RD_LAST : w_wr_last;
               rd_sr_d   = 32'd0;
            end
         end
         S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA: begin
            if (!sck_q) begin
               sck_d = 1'b1;
               if (state_q == S_RDATA) rd_sr_d = {rd_sr_q[27:0], psram_dio_in_i};
            end else begin
               sck_d = 1'b0;
               if (k_q == last_k_q) begin
                  state_d = S_CEHOLD;
                  hold_d  = C_HOLD_TXN;
                  if (rstcmd_q) begin
                     seq_d = seq_q - 2'd1;
                  end else begin
                     ready_d = 1'b1;
                     if (rd_q) rdata_d = bswap(rd_sr_q);
                  end
               end else begin
                  k_d = k_q + 8'd1;
                  case (state_q)
                     S_CMD:
                        if (k_q == 8'd8) state_d = S_ADDR;
                        else cmd_sr_d = {cmd_sr_q[6:0], 1'b0};
                     S_ADDR:
                        if (k_q == 8'd14)
                           state_d = !rd_q ? S_WDATA :
                                     (DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY;
                        else addr_sr_d = {addr_sr_q[19:0], 4'h0};
                     S_DUMMY:
                        if (k_q == C_DUMMY_END) state_d = S_RDATA;
                     S_WDATA:
                        wr_sr_d = {wr_sr_q[27:0], 4'h0};
                     default: ;
                  endcase
               end
            end
         end
         S_CEHOLD: begin
            if (hold_q == 8'd0) state_d = S_IDLE;
            else hold_d = hold_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      psram_ce_n_o    = 1'b1;
      psram_dio_oe_o  = 1'b0;
      psram_dio_out_o = 4'h0;
      case (state_q)
         S_CMD: begin
            psram_ce_n_o    = 1'b0;
            psram_dio_oe_o  = 1'b1;
            psram_dio_out_o = {3'b000, cmd_sr_q[7]};
         end
         S_ADDR: begin
            psram_ce_n_o    = 1'b0;
            psram_dio_oe_o  = 1'b1;
            psram_dio_out_o = addr_sr_q[23:20];
         end
         S_DUMMY, S_RDATA: begin
            psram_ce_n_o    = 1'b0;
         end
         S_WDATA: begin
            psram_ce_n_o    = 1'b0;
            psram_dio_oe_o  = 1'b1;
            psram_dio_out_o = wr_sr_q[31:28];
         end
         default: ;
      endcase
   end

   assign psram_sck_o = sck_q;
   assign bus.ready   = ready_q;
   assign bus.rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psram_qspi_ctrl
//  Purpose  : Self-checking bench for psram_qspi_ctrl with a behavioural
//             quad-SPI PSRAM device and a byte-level reference memory.
//  Options  : PSRAM_RESET_SEQ_EN - also checks the 66h/99h reset sequence
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psram_qspi_ctrl;
   localparam int D   = 6;
   localparam int CEH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck, ce_n, oe;
   logic [3:0] dout;
   logic [3:0] din = 4'h0;

   always #5 clk = ~clk;

   psram_qspi_ctrl_if bus ();

   psram_qspi_ctrl #(.DUMMY_CYCLES(D), .CE_HIGH(CEH)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .psram_sck_o     (sck),
      .psram_ce_n_o    (ce_n),
      .psram_dio_out_o (dout),
      .psram_dio_oe_o  (oe),
      .psram_dio_in_i  (din)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural PSRAM device ----------------
   typedef struct { logic [7:0] cmd; logic [23:0] addr; int nclk; } rec_t;
   rec_t       recq[$];
   logic [7:0] dmem [int];
   int         dcnt = 0;
   logic [7:0] dcmd = 8'h00;
   logic [23:0] dadr = 24'h0;
   int         proto_viol = 0;

   function automatic logic [7:0] dev_rd(input int a);
      return dmem.exists(a) ? dmem[a] : 8'h00;
   endfunction

   always @(negedge ce_n) begin
      dcnt = 0; dcmd = 8'h00; dadr = 24'h0;
   end

   always @(posedge ce_n) begin
      if (dcnt > 0) recq.push_back('{dcmd, dadr, dcnt});
      dcnt = 0;
   end

   always @(posedge sck) begin
      if (ce_n === 1'b0) begin
         dcnt++;
         if (dcnt <= 8) begin
            dcmd = {dcmd[6:0], dout[0]};
            if (dout[3:1] !== 3'b000 || oe !== 1'b1) proto_viol++;
         end else if (dcnt <= 14) begin
            dadr = {dadr[19:0], dout};
            if (oe !== 1'b1) proto_viol++;
         end else if (dcmd == 8'h38) begin
            int j, idx;
            logic [7:0] b;
            j   = dcnt - 15;
            idx = int'(dadr) + j / 2;
            b   = dev_rd(idx);
            if (j % 2 == 0) b[7:4] = dout; else b[3:0] = dout;
            dmem[idx] = b;
            if (oe !== 1'b1) proto_viol++;
         end else if (dcmd == 8'hEB) begin
            if (oe !== 1'b0) proto_viol++;
         end
      end
   end

   always @(negedge sck) begin
      if (ce_n === 1'b0 && dcmd == 8'hEB && dcnt >= 14 + D) begin
         int m;
         logic [7:0] b;
         m   = dcnt - (14 + D);
         b   = dev_rd(int'(dadr) + m / 2);
         din = (m % 2 == 0) ? b[7:4] : b[3:0];
      end
   end

   // ---------------- protocol monitors ----------------
   int sck_viol = 0, ready_cnt = 0, ready_wide = 0, hi_run = 0, min_gap = 1000;
   logic prev_ready = 1'b0;

   always @(negedge clk) begin
      if (ce_n === 1'b1 && sck !== 1'b0) sck_viol++;
      if (bus.ready === 1'b1) ready_cnt++;
      if (bus.ready === 1'b1 && prev_ready === 1'b1) ready_wide++;
      prev_ready = bus.ready;
      if (ce_n === 1'b1) hi_run++;
      else begin
         if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         hi_run = 0;
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [int];
   int n_req = 0;

   function automatic logic [7:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic do_req(input logic [23:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit keep);
      bit          is_rd;
      int          f, l, nclk, c0, cyc, wa;
      logic [23:0] ea;
      logic [31:0] er;
      rec_t        r;
      is_rd = (ws == 4'b0000);
      wa    = int'({a[23:2], 2'b00});
      f = 0; l = 0; er = 32'h0;
      for (int i = 3; i >= 0; i--) if (ws[i]) f = i;
      for (int i = 0; i < 4; i++)  if (ws[i]) l = i;
      if (is_rd) begin
         ea   = 24'(wa);
         nclk = 14 + D + 8;
         er   = {ref_rd(wa + 3), ref_rd(wa + 2), ref_rd(wa + 1), ref_rd(wa)};
      end else begin
         ea   = 24'(wa + f);
         nclk = 14 + 2 * (l - f + 1);
         for (int i = f; i <= l; i++) ref_mem[wa + i] = wd[8*i +: 8];
      end
      n_req++;
      bus.valid = 1'b1; bus.addr = a; bus.wdata = wd; bus.wstrb = ws;
      c0 = -1; cyc = 0;
      while (cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         if (c0 < 0 && ce_n === 1'b0) c0 = cyc;
         if (bus.ready === 1'b1) break;
      end
      chk("ready_seen", {31'd0, bus.ready}, 32'd1);
      chk("ready_latency", 32'(cyc - c0), 32'(2 * nclk));
      if (is_rd) chk("rdata", bus.rdata, er);
      if (!keep) bus.valid = 1'b0;
      chk("txn_count", 32'(recq.size()), 32'd1);
      if (recq.size() > 0) begin
         r = recq.pop_front();
         chk("cmd", {24'd0, r.cmd}, is_rd ? 32'hEB : 32'h38);
         chk("start_addr", {8'd0, r.addr}, {8'd0, ea});
         chk("sck_clocks", 32'(r.nclk), 32'(nclk));
      end
      recq.delete();
   endtask

   // Waits out the optional 66h/99h sequence after a reset release.
   task automatic reset_seq_drain();
`ifdef PSRAM_RESET_SEQ_EN
      int cyc;
      cyc = 0;
      while (cyc < 200 && recq.size() < 2) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("seq_txns", 32'(recq.size()), 32'd2);
      if (recq.size() >= 2) begin
         chk("seq_cmd0", {24'd0, recq[0].cmd}, 32'h66);
         chk("seq_cmd1", {24'd0, recq[1].cmd}, 32'h99);
         chk("seq_clk0", 32'(recq[0].nclk), 32'd8);
         chk("seq_clk1", 32'(recq[1].nclk), 32'd8);
      end
      recq.delete();
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, cyc;
      bus.valid = 1'b0; bus.addr = 24'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_ce_n",  {31'd0, ce_n}, 32'd1);
      chk("rst_sck",   {31'd0, sck},  32'd0);
      chk("rst_oe",    {31'd0, oe},   32'd0);
      chk("rst_dout",  {28'd0, dout}, 32'd0);
      chk("rst_ready", {31'd0, bus.ready}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      rst = 1'b0;

      // Request pending during any power-up command sequence
      bus.valid = 1'b1; bus.addr = 24'h0; bus.wstrb = 4'h0;
      reset_seq_drain();
      chk("no_ready_before_seq", 32'(ready_cnt), 32'd0);
      do_req(24'h000000, 32'h0, 4'b0000, 1'b0);

      // Directed cases
      do_req(24'h000100, 32'h12345678, 4'b1111, 1'b0);
      chk("dev_byte0", {24'd0, dev_rd(32'h100)}, 32'h78);
      chk("dev_byte3", {24'd0, dev_rd(32'h103)}, 32'h12);
      do_req(24'h000100, 32'h0, 4'b0000, 1'b0);
      do_req(24'h000100, 32'h0000AB00, 4'b0010, 1'b0);
      do_req(24'h000100, 32'h0, 4'b0000, 1'b0);
      chk("byte_merge", bus.rdata, 32'h1234AB78);
      do_req(24'h000200, 32'hCAFE0000, 4'b1100, 1'b0);
      do_req(24'h000200, 32'h0, 4'b0000, 1'b0);
      chk("half_upper", {16'd0, bus.rdata[31:16]}, 32'h0000CAFE);

      // Back-to-back reads, valid held across both
      do_req(24'h000100, 32'h0, 4'b0000, 1'b1);
      do_req(24'h000200, 32'h0, 4'b0000, 1'b0);

      // Reset during the dummy phase of a read
      bus.valid = 1'b1; bus.addr = 24'h000100; bus.wstrb = 4'h0;
      cyc = 0;
      while (cyc < 50 && ce_n !== 1'b0) begin @(posedge clk); #1; cyc++; end
      chk("midrst_started", {31'd0, ce_n}, 32'd0);
      repeat (32) begin @(posedge clk); #1; end
      rc = ready_cnt;
      #2 rst = 1'b1;
      #1;
      chk("midrst_ce_n", {31'd0, ce_n}, 32'd1);
      chk("midrst_sck",  {31'd0, sck},  32'd0);
      chk("midrst_oe",   {31'd0, oe},   32'd0);
      bus.valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      chk("midrst_no_ready", 32'(ready_cnt), 32'(rc));
      recq.delete();
      reset_seq_drain();
      do_req(24'h000100, 32'h0, 4'b0000, 1'b0);

      // Randomized traffic
      for (int it = 0; it < 24; it++) begin
         logic [23:0] a;
         logic [3:0]  ws;
         int          f, l;
         a  = 24'h000300 + 24'($urandom_range(0, 15)) * 24'd4 + 24'($urandom_range(0, 3));
         ws = 4'b0000;
         if ($urandom_range(0, 2) != 0) begin
            f = $urandom_range(0, 3);
            l = $urandom_range(f, 3);
            for (int i = f; i <= l; i++) ws[i] = 1'b1;
         end
         do_req(a, $urandom, ws, 1'b0);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      repeat (5) begin @(posedge clk); #1; end
      chk("sck_while_ce_high", 32'(sck_viol), 32'd0);
      chk("ready_pulse_wide",  32'(ready_wide), 32'd0);
      chk("ready_per_request", 32'(ready_cnt), 32'(n_req));
      chk("ce_gap_short",      {31'd0, (min_gap < CEH)}, 32'd0);
      chk("dio_protocol",      32'(proto_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
